fifo_frame_reader: RTL and testbench
====================================

FIFO_FRAME_READER -- requirements
Module: fifo_frame_reader

Interface
REQ-001 The block SHALL take parameter MAX_LEN, default 1472, the largest accepted payload length in bytes.
REQ-002 The block SHALL take parameter LEN_WIDTH, default 16, the width of the length field and the byte counter.
REQ-003 Port clk SHALL be an input, 1 bit, the single rising-edge clock.
REQ-004 Port rst SHALL be an input, 1 bit, synchronous active-high reset, sampled on clk.
REQ-005 Port fifo_dout SHALL be an input, 8 bits, the head byte of the upstream byte FIFO.
REQ-006 Port fifo_dout SHALL be treated as first-word-fall-through: valid whenever fifo_empty is low.
REQ-007 Port fifo_empty SHALL be an input, 1 bit, high when the upstream FIFO holds no byte.
REQ-008 Port fifo_rd_en SHALL be an output, 1 bit, a pop strobe that advances the upstream FIFO by one byte at the same clk edge.
REQ-009 Port m_axis_tdata SHALL be an output, 8 bits, the payload byte.
REQ-010 Port m_axis_tvalid SHALL be an output, 1 bit, high while m_axis_tdata holds a byte.
REQ-011 Port m_axis_tready SHALL be an input, 1 bit, the downstream accept signal.
REQ-012 Port m_axis_tlast SHALL be an output, 1 bit, marking the final byte of a frame.
REQ-013 Port busy SHALL be an output, 1 bit, high whenever the state is not LEN_HI.
REQ-014 Port err_cnt SHALL be an output, 8 bits, a saturating count of rejected frames.

Function
REQ-015 Input bytes SHALL form records: length high byte, length low byte (big-endian), then exactly that many payload bytes.
REQ-016 The FSM SHALL have exactly four states: LEN_HI, LEN_LO, PAYLOAD, DISCARD.
REQ-017 In LEN_HI, fifo_rd_en SHALL equal ~fifo_empty, and a pop SHALL latch fifo_dout into len[15:8] and move to LEN_LO.
REQ-018 In LEN_LO, fifo_rd_en SHALL equal ~fifo_empty, and a pop SHALL form L = {len_hi, fifo_dout} and set the remaining-byte counter rem to L.
REQ-019 On a LEN_LO pop: L=0 SHALL return to LEN_HI, silently skipping the record with no output and no error.
REQ-020 On a LEN_LO pop: 1 <= L <= MAX_LEN SHALL go to PAYLOAD.
REQ-021 On a LEN_LO pop: L > MAX_LEN SHALL go to DISCARD and increment err_cnt, saturating at 255.
REQ-022 In PAYLOAD, fifo_rd_en SHALL equal ~fifo_empty & (~m_axis_tvalid | m_axis_tready).
REQ-023 On each PAYLOAD pop, fifo_dout SHALL load into m_axis_tdata, m_axis_tvalid SHALL be set, m_axis_tlast SHALL be set to (rem==1), and rem SHALL decrement.
REQ-024 When the PAYLOAD pop with rem==1 occurs, the next state SHALL be LEN_HI.
REQ-025 In DISCARD, fifo_rd_en SHALL equal ~fifo_empty, each pop SHALL decrement rem, and the pop with rem==1 SHALL return to LEN_HI; the output SHALL be untouched.
REQ-026 Latency SHALL be one cycle: a byte popped at edge N is presented on m_axis_tdata after edge N.
REQ-027 A handshake without a new load (tvalid & tready & no pop) SHALL clear m_axis_tvalid and m_axis_tlast.
REQ-028 Holding rule: while tvalid=1 and tready=0, tdata and tlast SHALL be stable and no PAYLOAD pop SHALL occur.
REQ-029 Throughput: with the FIFO non-empty and tready held high, PAYLOAD SHALL sustain one byte per cycle.
REQ-030 The next frame's LEN_HI pop MAY occur while the previous tlast byte is still held.
REQ-031 fifo_rd_en SHALL never assert while fifo_empty=1.
REQ-032 fifo_rd_en SHALL be combinational from current state and inputs.

Reset
REQ-033 rst SHALL force state LEN_HI, rem=0, len_hi=0, m_axis_tvalid=0, m_axis_tlast=0, m_axis_tdata=0, err_cnt=0.
REQ-034 While rst is high, fifo_rd_en SHALL be 0.
REQ-035 A reset asserted mid-frame SHALL abandon the frame with no tlast emitted.
REQ-036 Re-synchronisation to the byte stream after reset is the upstream's responsibility; the upstream FIFO is reset alongside this block.

Structure
REQ-037 State encoding and MAX_LEN default SHALL reside in shared package ether_pkg.
REQ-038 The block SHALL be a single module with no sub-modules; the output register SHALL be inline.

Verification
REQ-039 Bench: record 00 03 AA BB CC, tready=1 -> AA,BB,CC on 3 consecutive cycles, tlast only on CC, err_cnt=0.
REQ-040 Bench: record 00 00 followed by 00 01 5A -> single-byte frame 5A with tlast=1, nothing emitted for the zero-length record.
REQ-041 Bench: record 05 DC + 1500 bytes, then 00 01 77 (MAX_LEN=1472) -> no output for the first record, err_cnt=1, then frame 77 with tlast.
REQ-042 Bench: 4-byte frame with tready toggling 1,0,0,1,... -> tdata/tlast stable during stalls, fifo_rd_en low during stalls, bytes in order.
REQ-043 Bench: fifo_empty pulsed high mid-payload for 3 cycles -> no pop, no spurious tvalid, frame completes intact.
REQ-044 Bench: rst asserted after 2 of 6 payload bytes -> all outputs zero next cycle, state LEN_HI, busy=0.

Source files
------------

// File: rtl/ether_pkg.sv
// Shared definitions for the Ethernet-side byte-stream blocks:
// the frame-reader state encoding and the default payload limit.
package ether_pkg;

  typedef enum logic [1:0] {
    LEN_HI  = 2'd0,
    LEN_LO  = 2'd1,
    PAYLOAD = 2'd2,
    DISCARD = 2'd3
  } state_e;

  localparam int MAX_LEN_DEFAULT = 1472;

endpackage

// File: rtl/fifo_frame_reader_if.sv
// Byte-FIFO read side plus AXI-Stream master side of the frame reader.
// master = the reader itself, slave = the environment around it.
interface fifo_frame_reader_if;

  logic [7:0] fifo_dout;
  logic       fifo_empty;
  logic       fifo_rd_en;
  logic [7:0] m_axis_tdata;
  logic       m_axis_tvalid;
  logic       m_axis_tready;
  logic       m_axis_tlast;

  modport master (
    input  fifo_dout, fifo_empty, m_axis_tready,
    output fifo_rd_en, m_axis_tdata, m_axis_tvalid, m_axis_tlast
  );

  modport slave (
    output fifo_dout, fifo_empty, m_axis_tready,
    input  fifo_rd_en, m_axis_tdata, m_axis_tvalid, m_axis_tlast
  );

endinterface

// File: rtl/fifo_frame_reader.sv
// Splits a length-prefixed byte stream from an FWFT FIFO into AXI-Stream frames;
// oversize records are drained silently and counted in err_cnt.
module fifo_frame_reader
  import ether_pkg::*;
#(
  parameter int MAX_LEN   = MAX_LEN_DEFAULT,
  parameter int LEN_WIDTH = 16
) (
  input  logic                clk,
  input  logic                rst,
  fifo_frame_reader_if.master bus,
  output logic                busy,
  output logic [7:0]          err_cnt
);

  state_e               state_q, state_d;
  logic [7:0]           len_hi_q, len_hi_d;
  logic [LEN_WIDTH-1:0] rem_q, rem_d;
  logic [LEN_WIDTH-1:0] len_l;
  logic [7:0]           tdata_q, tdata_d;
  logic                 tvalid_q, tvalid_d;
  logic                 tlast_q, tlast_d;
  logic [7:0]           err_q, err_d;
  logic                 pop;
  logic                 rem_one;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  assign len_l   = LEN_WIDTH'({len_hi_q, bus.fifo_dout});
  assign rem_one = (rem_q == LEN_WIDTH'(1));

  always_comb begin
    state_d  = state_q;
    len_hi_d = len_hi_q;
    rem_d    = rem_q;
    tdata_d  = tdata_q;
    tvalid_d = tvalid_q;
    tlast_d  = tlast_q;
    err_d    = err_q;
    pop      = 1'b0;

    // A completed handshake empties the output register unless refilled below.
    if (tvalid_q && bus.m_axis_tready) begin
      tvalid_d = 1'b0;
      tlast_d  = 1'b0;
    end

    case (state_q)
      LEN_HI: begin
        pop = ~bus.fifo_empty;
        if (pop) begin
          len_hi_d = bus.fifo_dout;
          state_d  = LEN_LO;
        end
      end
      LEN_LO: begin
        pop = ~bus.fifo_empty;
        if (pop) begin
          rem_d = len_l;
          if (len_l == '0) begin
            state_d = LEN_HI;
          end else if (len_l > LEN_WIDTH'(MAX_LEN)) begin
            state_d = DISCARD;
            err_d   = sat_inc8(err_q);
          end else begin
            state_d = PAYLOAD;
          end
        end
      end
      PAYLOAD: begin
        pop = ~bus.fifo_empty & (~tvalid_q | bus.m_axis_tready);
        if (pop) begin
          tdata_d  = bus.fifo_dout;
          tvalid_d = 1'b1;
          tlast_d  = rem_one;
          rem_d    = rem_q - LEN_WIDTH'(1);
          if (rem_one) state_d = LEN_HI;
        end
      end
      DISCARD: begin
        pop = ~bus.fifo_empty;
        if (pop) begin
          rem_d = rem_q - LEN_WIDTH'(1);
          if (rem_one) state_d = LEN_HI;
        end
      end
      default: state_d = LEN_HI;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= LEN_HI;
      len_hi_q <= '0;
      rem_q    <= '0;
      tdata_q  <= '0;
      tvalid_q <= 1'b0;
      tlast_q  <= 1'b0;
      err_q    <= '0;
    end else begin
      state_q  <= state_d;
      len_hi_q <= len_hi_d;
      rem_q    <= rem_d;
      tdata_q  <= tdata_d;
      tvalid_q <= tvalid_d;
      tlast_q  <= tlast_d;
      err_q    <= err_d;
    end
  end

  assign bus.fifo_rd_en    = pop & ~rst;
  assign bus.m_axis_tdata  = tdata_q;
  assign bus.m_axis_tvalid = tvalid_q;
  assign bus.m_axis_tlast  = tlast_q;
  assign busy              = (state_q != LEN_HI);
  assign err_cnt           = err_q;

endmodule

// File: tb/tb_fifo_frame_reader.sv
// Directed bench for fifo_frame_reader: a queue-backed FWFT FIFO feeds the DUT,
// handshaked output beats are collected and compared against hand-derived values.
module tb_fifo_frame_reader;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       busy;
  logic [7:0] err_cnt;

  fifo_frame_reader_if bus ();

  fifo_frame_reader #(.MAX_LEN(1472), .LEN_WIDTH(16)) dut (
    .clk    (clk),
    .rst    (rst),
    .bus    (bus),
    .busy   (busy),
    .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] d;
    logic       l;
    int         c;
  } beat_t;

  int         n_cmp = 0;
  int         n_bad = 0;
  logic [7:0] q[$];
  beat_t      outq[$];
  logic       hold_empty = 1'b0;
  int         cyc = 0;
  int         pops = 0;
  int         viol = 0;

  // FIFO pop and output capture happen on the active edge.
  always @(posedge clk) begin
    cyc++;
    if (bus.m_axis_tvalid && bus.m_axis_tready)
      outq.push_back('{d: bus.m_axis_tdata, l: bus.m_axis_tlast, c: cyc});
    if (bus.fifo_rd_en) begin
      if (bus.fifo_empty || q.size() == 0) viol++;
      else begin
        q.delete(0);
        pops++;
      end
    end
  end

  // FIFO head is republished 2 time units after each falling edge.
  always begin
    @(negedge clk);
    #2;
    bus.fifo_empty = (q.size() == 0) || hold_empty;
    bus.fifo_dout  = (q.size() != 0) ? q[0] : 8'h00;
  end

  task automatic wait_out(input int n, input int budget, output bit ok);
    for (int i = 0; i < budget && outq.size() < n; i++) @(negedge clk);
    ok = (outq.size() >= n);
  endtask

  task automatic test_reset();
    @(negedge clk);
    q.push_back(8'h12);
    bus.m_axis_tready = 1'b1;
    repeat (2) @(negedge clk);
    #3;
    n_cmp++; if (bus.m_axis_tvalid !== 1'b0) begin n_bad++; $display("FAIL rst_tvalid: got %b want 0", bus.m_axis_tvalid); end
    n_cmp++; if (bus.m_axis_tlast !== 1'b0) begin n_bad++; $display("FAIL rst_tlast: got %b want 0", bus.m_axis_tlast); end
    n_cmp++; if (bus.m_axis_tdata !== 8'h00) begin n_bad++; $display("FAIL rst_tdata: got %h want 00", bus.m_axis_tdata); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL rst_busy: got %b want 0", busy); end
    n_cmp++; if (err_cnt !== 8'h00) begin n_bad++; $display("FAIL rst_err: got %0d want 0", err_cnt); end
    n_cmp++; if (bus.fifo_rd_en !== 1'b0) begin n_bad++; $display("FAIL rst_rd_en: got %b want 0", bus.fifo_rd_en); end
    @(negedge clk);
    q.delete();
    outq.delete();
    rst = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_basic();
    logic [7:0] exp_b[3];
    bit ok;
    exp_b[0] = 8'hAA; exp_b[1] = 8'hBB; exp_b[2] = 8'hCC;
    outq.delete();
    bus.m_axis_tready = 1'b1;
    q.push_back(8'h00); q.push_back(8'h03);
    q.push_back(8'hAA); q.push_back(8'hBB); q.push_back(8'hCC);
    wait_out(3, 50, ok);
    n_cmp++; if (!ok) begin n_bad++; $display("FAIL basic_timeout: got %0d beats want 3", outq.size()); end
    if (ok) begin
      for (int i = 0; i < 3; i++) begin
        n_cmp++; if (outq[i].d !== exp_b[i]) begin n_bad++; $display("FAIL basic_data[%0d]: got %h want %h", i, outq[i].d, exp_b[i]); end
        n_cmp++; if (outq[i].l !== (i == 2)) begin n_bad++; $display("FAIL basic_last[%0d]: got %b want %b", i, outq[i].l, (i == 2)); end
        n_cmp++; if (outq[i].c - outq[0].c !== i) begin n_bad++; $display("FAIL basic_gap[%0d]: got %0d want %0d", i, outq[i].c - outq[0].c, i); end
      end
    end
    repeat (4) @(negedge clk);
    #3;
    n_cmp++; if (outq.size() != 3) begin n_bad++; $display("FAIL basic_count: got %0d want 3", outq.size()); end
    n_cmp++; if (err_cnt !== 8'h00) begin n_bad++; $display("FAIL basic_err: got %0d want 0", err_cnt); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL basic_busy: got %b want 0", busy); end
  endtask

  task automatic test_zero_len();
    bit ok;
    outq.delete();
    q.push_back(8'h00); q.push_back(8'h00);
    q.push_back(8'h00); q.push_back(8'h01); q.push_back(8'h5A);
    wait_out(1, 50, ok);
    repeat (5) @(negedge clk);
    n_cmp++; if (outq.size() != 1) begin n_bad++; $display("FAIL zero_count: got %0d want 1", outq.size()); end
    if (ok) begin
      n_cmp++; if (outq[0].d !== 8'h5A) begin n_bad++; $display("FAIL zero_data: got %h want 5a", outq[0].d); end
      n_cmp++; if (outq[0].l !== 1'b1) begin n_bad++; $display("FAIL zero_last: got %b want 1", outq[0].l); end
    end
  endtask

  task automatic test_oversize();
    bit ok;
    outq.delete();
    q.push_back(8'h05); q.push_back(8'hDC);
    for (int i = 0; i < 1500; i++) q.push_back(8'(i));
    q.push_back(8'h00); q.push_back(8'h01); q.push_back(8'h77);
    wait_out(1, 2000, ok);
    repeat (4) @(negedge clk);
    #3;
    n_cmp++; if (outq.size() != 1) begin n_bad++; $display("FAIL over_count: got %0d want 1", outq.size()); end
    if (ok) begin
      n_cmp++; if (outq[0].d !== 8'h77) begin n_bad++; $display("FAIL over_data: got %h want 77", outq[0].d); end
      n_cmp++; if (outq[0].l !== 1'b1) begin n_bad++; $display("FAIL over_last: got %b want 1", outq[0].l); end
    end
    n_cmp++; if (err_cnt !== 8'd1) begin n_bad++; $display("FAIL over_err: got %0d want 1", err_cnt); end
  endtask

  task automatic test_stall();
    logic [7:0] exp_b[4];
    logic       pat[4];
    logic       prev_stall;
    logic [7:0] prev_d;
    logic       prev_l;
    logic       stall;
    exp_b[0] = 8'h11; exp_b[1] = 8'h22; exp_b[2] = 8'h33; exp_b[3] = 8'h44;
    pat[0] = 1'b1; pat[1] = 1'b0; pat[2] = 1'b0; pat[3] = 1'b1;
    prev_stall = 1'b0; prev_d = 8'h00; prev_l = 1'b0;
    outq.delete();
    q.push_back(8'h00); q.push_back(8'h04);
    for (int i = 0; i < 4; i++) q.push_back(exp_b[i]);
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      bus.m_axis_tready = pat[c % 4];
      #3;
      stall = bus.m_axis_tvalid && !bus.m_axis_tready;
      if (prev_stall) begin
        n_cmp++; if (bus.m_axis_tdata !== prev_d || bus.m_axis_tlast !== prev_l || bus.m_axis_tvalid !== 1'b1) begin
          n_bad++; $display("FAIL stall_hold c%0d: got v%b d%h l%b want v1 d%h l%b", c, bus.m_axis_tvalid, bus.m_axis_tdata, bus.m_axis_tlast, prev_d, prev_l);
        end
      end
      if (stall) begin
        n_cmp++; if (bus.fifo_rd_en !== 1'b0) begin n_bad++; $display("FAIL stall_rd_en c%0d: got %b want 0", c, bus.fifo_rd_en); end
      end
      prev_stall = stall;
      prev_d = bus.m_axis_tdata;
      prev_l = bus.m_axis_tlast;
    end
    bus.m_axis_tready = 1'b1;
    n_cmp++; if (outq.size() != 4) begin n_bad++; $display("FAIL stall_count: got %0d want 4", outq.size()); end
    if (outq.size() == 4) begin
      for (int i = 0; i < 4; i++) begin
        n_cmp++; if (outq[i].d !== exp_b[i] || outq[i].l !== (i == 3)) begin
          n_bad++; $display("FAIL stall_beat[%0d]: got %h/%b want %h/%b", i, outq[i].d, outq[i].l, exp_b[i], (i == 3));
        end
      end
    end
  endtask

  task automatic test_empty_gap();
    int  p0;
    bit  ok;
    outq.delete();
    bus.m_axis_tready = 1'b1;
    p0 = pops;
    q.push_back(8'h00); q.push_back(8'h04);
    for (int i = 1; i <= 4; i++) q.push_back(8'(i));
    for (int i = 0; i < 50 && (pops - p0) < 4; i++) @(negedge clk);
    hold_empty = 1'b1;
    #3;
    n_cmp++; if (bus.fifo_rd_en !== 1'b0) begin n_bad++; $display("FAIL gap_rd_en0: got %b want 0", bus.fifo_rd_en); end
    n_cmp++; if (bus.m_axis_tvalid !== 1'b1 || bus.m_axis_tdata !== 8'h02) begin
      n_bad++; $display("FAIL gap_held: got v%b d%h want v1 d02", bus.m_axis_tvalid, bus.m_axis_tdata);
    end
    for (int k = 1; k < 3; k++) begin
      @(negedge clk);
      #3;
      n_cmp++; if (bus.fifo_rd_en !== 1'b0) begin n_bad++; $display("FAIL gap_rd_en%0d: got %b want 0", k, bus.fifo_rd_en); end
      n_cmp++; if (bus.m_axis_tvalid !== 1'b0) begin n_bad++; $display("FAIL gap_tvalid%0d: got %b want 0", k, bus.m_axis_tvalid); end
    end
    @(negedge clk);
    hold_empty = 1'b0;
    wait_out(4, 50, ok);
    n_cmp++; if (!ok) begin n_bad++; $display("FAIL gap_timeout: got %0d beats want 4", outq.size()); end
    if (ok) begin
      for (int i = 0; i < 4; i++) begin
        n_cmp++; if (outq[i].d !== 8'(i + 1) || outq[i].l !== (i == 3)) begin
          n_bad++; $display("FAIL gap_beat[%0d]: got %h/%b want %h/%b", i, outq[i].d, outq[i].l, 8'(i + 1), (i == 3));
        end
      end
    end
    n_cmp++; if (pops - p0 != 6) begin n_bad++; $display("FAIL gap_pops: got %0d want 6", pops - p0); end
  endtask

  task automatic test_reset_mid();
    int n0;
    int lasts;
    bit ok;
    outq.delete();
    bus.m_axis_tready = 1'b1;
    q.push_back(8'h00); q.push_back(8'h06);
    for (int i = 0; i < 6; i++) q.push_back(8'hA0 + 8'(i));
    wait_out(2, 50, ok);
    n_cmp++; if (!ok) begin n_bad++; $display("FAIL rmid_timeout: got %0d beats want 2", outq.size()); end
    rst = 1'b1;
    @(negedge clk);
    #3;
    n_cmp++; if (bus.m_axis_tvalid !== 1'b0 || bus.m_axis_tlast !== 1'b0 || bus.m_axis_tdata !== 8'h00) begin
      n_bad++; $display("FAIL rmid_out: got v%b l%b d%h want v0 l0 d00", bus.m_axis_tvalid, bus.m_axis_tlast, bus.m_axis_tdata);
    end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL rmid_busy: got %b want 0", busy); end
    n_cmp++; if (err_cnt !== 8'h00) begin n_bad++; $display("FAIL rmid_err: got %0d want 0", err_cnt); end
    n_cmp++; if (bus.fifo_rd_en !== 1'b0) begin n_bad++; $display("FAIL rmid_rd_en: got %b want 0", bus.fifo_rd_en); end
    @(negedge clk);
    q.delete();
    rst = 1'b0;
    lasts = 0;
    foreach (outq[i]) if (outq[i].l) lasts++;
    n_cmp++; if (lasts != 0) begin n_bad++; $display("FAIL rmid_tlast: got %0d tlast beats want 0", lasts); end
    n0 = outq.size();
    q.push_back(8'h00); q.push_back(8'h01); q.push_back(8'h99);
    wait_out(n0 + 1, 50, ok);
    n_cmp++; if (!ok || outq[outq.size() - 1].d !== 8'h99 || outq[outq.size() - 1].l !== 1'b1) begin
      n_bad++; $display("FAIL rmid_resync: got %0d beats want %0d ending 99/last", outq.size(), n0 + 1);
    end
  endtask

  initial begin
    bus.m_axis_tready = 1'b0;
    test_reset();
    test_basic();
    test_zero_len();
    test_oversize();
    test_stall();
    test_empty_gap();
    test_reset_mid();
    n_cmp++; if (viol != 0) begin n_bad++; $display("FAIL rd_en_while_empty: got %0d pops want 0", viol); end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
